// File: rtl/press_detect_n.sv
// press_detect_n
//   Multi-channel push-button front end. Each raw button level passes through
//   a two-flop synchronizer and a debounce filter. An accepted level change
//   (a "flip") that matches the edge selected by mode produces a one-cycle
//   pulse and bumps a saturating per-channel event counter.
//
// Parameters
//   CHANNELS  number of independent button channels
//   DEBOUNCE  consecutive stable synchronized cycles required to accept a change
//   CNT_W     width of each per-channel event counter
//
// Ports
//   Clock    in   1               rising-edge clock
//   Reset    in   1               synchronous, active-high reset
//   pressed  in   CHANNELS        raw asynchronous button levels, 1 = pressed
//   stop     in   1               drop event pulses and counting while high
//   mode     in   2               00 rising, 01 falling, 10 both, 11 rising
//   clear    in   1               synchronous clear of all event counters
//   level    out  CHANNELS        debounced button level
//   pull     out  CHANNELS        one-cycle event pulse
//   count    out  CHANNELS*CNT_W  event counts, channel i at [i*CNT_W +: CNT_W]
module press_detect_n #(
  parameter int CHANNELS = 4,
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [CHANNELS-1:0]       pressed,
  input  logic                      stop,
  input  logic [1:0]                mode,
  input  logic                      clear,
  output logic [CHANNELS-1:0]       level,
  output logic [CHANNELS-1:0]       pull,
  output logic [CHANNELS*CNT_W-1:0] count
);

  // Debounce counter width: clog2(DEBOUNCE), never narrower than one bit.
  localparam int               DBW     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DBW-1:0]   DB_MAX  = DBW'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [DBW-1:0]      db_cnt_q [CHANNELS];
  logic [DBW-1:0]      db_cnt_d [CHANNELS];
  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] pull_q;
  logic [CHANNELS-1:0] pull_d;
  logic [CNT_W-1:0]    count_q  [CHANNELS];
  logic [CNT_W-1:0]    count_d  [CHANNELS];
  logic [CHANNELS-1:0] flip_s;
  logic [CHANNELS-1:0] qual_s;

  // Debounce filter, edge qualification and event counting for every channel.
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    count_d  = count_q;
    pull_d   = '0;
    flip_s   = '0;
    qual_s   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      // The counter tracks how long the synchronized input has disagreed
      // with the accepted level; any agreement restarts it.
      if (sync2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_MAX) begin
        flip_s[i]   = 1'b1;
        level_d[i]  = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
      end

      // The new level (sync2) gives the flip direction: 1 = rising.
      case (mode)
        2'b01:   qual_s[i] = flip_s[i] & ~sync2_q[i];
        2'b10:   qual_s[i] = flip_s[i];
        default: qual_s[i] = flip_s[i] & sync2_q[i];
      endcase

      // Events seen while stop is high are discarded, not deferred.
      pull_d[i] = qual_s[i] & ~stop;

      // clear wins over a coincident increment; the pulse itself is unaffected.
      if (clear) begin
        count_d[i] = '0;
      end else if (pull_d[i] && (count_q[i] != CNT_MAX)) begin
        count_d[i] = count_q[i] + CNT_W'(1);
      end else begin
        count_d[i] = count_q[i];
      end
    end
  end

  // State registers: synchronizers, debounce counters, level, pulse, counts.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pull_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        db_cnt_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      sync1_q  <= pressed;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      pull_q   <= pull_d;
      db_cnt_q <= db_cnt_d;
      count_q  <= count_d;
    end
  end

  assign level = level_q;
  assign pull  = pull_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_count
    assign count[g*CNT_W +: CNT_W] = count_q[g];
  end

endmodule

// File: doc/press_detect_n.md
PRESS_DETECT_N -- requirements
Module: press_detect_n

Interface
REQ-001 The module SHALL have parameters, one per line: name, default, meaning.
- CHANNELS, 4, number of independent button channels (≥1)
- DEBOUNCE, 3, consecutive stable synchronized cycles required to accept a level change (≥1)
- CNT_W, 8, width of each per-channel event counter (≥1)

REQ-002 The module SHALL have ports, one per line: name, direction, width, meaning.
- Clock  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- pressed  in  CHANNELS  raw asynchronous button levels, 1 = pressed
- stop  in  1  suppresses event pulses and counting while high
- mode  in  2  edge select: 00 rising, 01 falling, 10 both, 11 rising
- clear  in  1  synchronous clear of all event counters
- level  out  CHANNELS  debounced button level per channel
- pull  out  CHANNELS  one-cycle event pulse per channel
- count  out  CHANNELS*CNT_W  per-channel event count; channel i occupies bits [i*CNT_W +: CNT_W]

REQ-003 Reset SHALL be Reset, synchronous, active-high; the clock SHALL be Clock.

Function
REQ-004 Each pressed bit SHALL pass through a dedicated 2-flop synchronizer (s1, then s2) before any other use.
REQ-005 Each channel SHALL hold a debounce counter of width clog2(DEBOUNCE), minimum 1 bit.
REQ-006 If s2 == level at an edge, the counter SHALL clear to 0.
REQ-007 If s2 != level and counter < DEBOUNCE-1, the counter SHALL increment.
REQ-008 If s2 != level and counter == DEBOUNCE-1, level SHALL take the value of s2 at that edge, and the counter SHALL clear (a "flip").
REQ-009 A raw change first sampled at edge k and held stable SHALL change level at edge k+DEBOUNCE+1.
REQ-010 A change held for fewer cycles (glitch) SHALL NOT flip level; the counter SHALL restart on the return.
REQ-011 A flip SHALL qualify when:
- rising flip (0→1) with mode 00 or 11
- falling flip (1→0) with mode 01
- either direction with mode 10
REQ-012 mode SHALL be sampled at the flip edge; a mode change affects only subsequent flips.
REQ-013 pull[i] SHALL be registered and high for exactly the one cycle after a qualifying flip edge on channel i when stop is low at that edge; otherwise it SHALL be low.
REQ-014 A qualifying flip while stop is high SHALL still update level, but SHALL be dropped: no pull pulse, no count increment, not deferred.
REQ-015 count[i] SHALL increment at the same edge that sets pull[i].
REQ-016 count[i] SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-017 clear high at an edge SHALL set all counts to 0, with priority over a simultaneous increment; pull SHALL still pulse normally.
REQ-018 Channels SHALL be fully independent; simultaneous flips on multiple channels SHALL each produce their own pulse and count.

Reset
REQ-019 While Reset is high at an edge, the following SHALL all clear to 0: s1, s2, debounce counters, level, pull, count.
REQ-020 Reset SHALL take priority over clear, stop and all input activity.
REQ-021 A debounce in progress SHALL be abandoned by Reset, with no pulse after Reset.
REQ-022 A button held high through Reset SHALL, with mode 00, produce a rising flip at edge e+DEBOUNCE+1, where e is the first edge with Reset low.

Verification
REQ-023 Defaults; pressed[0]=1 held through Reset; e = first edge with Reset low -> level[0]=1 and pull[0]=1 after edge e+4; pull[0] low after e+5; count[0]=1.
REQ-024 Defaults, mode 00; pressed[1] high for 2 cycles then low -> level[1], pull[1] and count[1] stay 0.
REQ-025 Defaults; channel 2 pressed, then released, each held 10 cycles:
- mode 01 -> one pulse on release only
- mode 10 -> two pulses; count[2]=2
REQ-026 Defaults, mode 00; stop=1 across the rising flip of channel 3 -> level[3]=1, pull[3] never high, count[3] unchanged.
REQ-027 CNT_W=2, mode 00; 5 full press/release cycles on channel 0 -> count[0]=3 (saturated). Then clear coincident with a qualifying flip -> count[0]=0 and pull[0]=1.
REQ-028 Defaults; Reset asserted when channel 1 debounce counter = 2 -> all outputs 0 the next cycle; no pull pulse after Reset while pressed[1] returns low.
